// File: rtl/sid_pkg.sv
// Shared SID definitions: register addresses, mixer state encoding and
// accumulator width offsets relative to the nominal 16-bit sample width.
package sid_pkg;

  localparam logic [4:0] SID_FILT_RES = 5'h17;
  localparam logic [4:0] SID_MODE_VOL = 5'h18;

  localparam int SID_W  = 16;
  localparam int FACC_W = SID_W + 2;
  localparam int DACC_W = SID_W + 3;
  localparam int PROD_W = SID_W + 11;

  typedef enum logic [2:0] {
    MIX_IDLE  = 3'd0,
    MIX_VOICE = 3'd1,
    MIX_FILT  = 3'd2,
    MIX_MUL   = 3'd3,
    MIX_OUT   = 3'd4
  } mix_state_e;

endpackage

// File: rtl/sid_sat.sv
// Combinational signed saturator: clamps an IW-bit value into OW bits.
module sid_sat #(
  parameter int IW = 18,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] in_i,
  output logic signed [OW-1:0] out_o
);

  logic [IW-OW:0] top;

  always_comb begin
    top = in_i[IW-1:OW-1];
    if ((&top) || ~(|top)) begin
      out_o = in_i[OW-1:0];
    end else if (in_i[IW-1]) begin
      out_o = {1'b1, {(OW-1){1'b0}}};
    end else begin
      out_o = {1'b0, {(OW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sid_mixer.sv
// SID audio router and master volume: per tick, splits voices between filter
// input and dry path, folds in filter mode outputs, and scales by 4-bit volume.
module sid_mixer
  import sid_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clkEn,
  input  logic signed [W-1:0] iV1,
  input  logic signed [W-1:0] iV2,
  input  logic signed [W-1:0] iV3,
  input  logic signed [W-1:0] iExt,
  input  logic signed [W-1:0] iLP,
  input  logic signed [W-1:0] iBP,
  input  logic signed [W-1:0] iHP,
  input  logic                WR,
  input  logic [4:0]          ADDR,
  input  logic [7:0]          DATA,
  output logic signed [W-1:0] oFiltIn,
  output logic signed [W-1:0] oOut,
  output logic                oValid
);

  localparam int FW = W + (FACC_W - SID_W);
  localparam int DW = W + (DACC_W - SID_W);
  localparam int PW = W + (PROD_W - SID_W);

  function automatic logic signed [FW-1:0] fext(input logic signed [W-1:0] x);
    return FW'(x);
  endfunction

  function automatic logic signed [DW-1:0] dext(input logic signed [W-1:0] x);
    return DW'(x);
  endfunction

  function automatic logic signed [PW-1:0] pext(input logic signed [DW-1:0] x);
    return PW'(x);
  endfunction

  logic [3:0]          fen_q, fen_d;
  logic [7:0]          mv_q, mv_d;
  logic signed [W-1:0] src_q [4];
  logic signed [W-1:0] src_d [4];
  logic signed [W-1:0] lp_q, lp_d, bp_q, bp_d, hp_q, hp_d;
  logic [3:0]          sfen_q, sfen_d;
  logic [7:0]          smv_q, smv_d;
  mix_state_e          st_q, st_d;
  logic [2:0]          cnt_q, cnt_d;
  logic signed [FW-1:0] facc_q, facc_d;
  logic signed [DW-1:0] dacc_q, dacc_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [W-1:0] filt_q, filt_d, out_q, out_d;
  logic                vld_q, vld_d;

  logic signed [W-1:0]  cur_src;
  logic [7:0]           vmul;
  logic signed [PW-1:0] prod_shr;
  logic signed [W-1:0]  sat_f, sat_o;

  assign cur_src  = src_q[cnt_q[1:0]];
  assign vmul     = {smv_q[3:0], smv_q[3:0]};
  assign prod_shr = prod_q >>> 8;

  sid_sat #(.IW(FW), .OW(W)) u_sat_filt (.in_i(facc_q),   .out_o(sat_f));
  sid_sat #(.IW(PW), .OW(W)) u_sat_out  (.in_i(prod_shr), .out_o(sat_o));

  always_comb begin
    fen_d  = fen_q;
    mv_d   = mv_q;
    src_d  = src_q;
    lp_d   = lp_q;
    bp_d   = bp_q;
    hp_d   = hp_q;
    sfen_d = sfen_q;
    smv_d  = smv_q;
    st_d   = st_q;
    cnt_d  = cnt_q;
    facc_d = facc_q;
    dacc_d = dacc_q;
    prod_d = prod_q;
    filt_d = filt_q;
    out_d  = out_q;
    vld_d  = 1'b0;

    if (WR && ADDR == SID_FILT_RES) fen_d = DATA[3:0];
    if (WR && ADDR == SID_MODE_VOL) mv_d  = DATA;

    case (st_q)
      MIX_VOICE: begin
        if (sfen_q[cnt_q[1:0]]) begin
          facc_d = facc_q + fext(cur_src);
        end else if (!(cnt_q == 3'd2 && smv_q[7])) begin
          dacc_d = dacc_q + dext(cur_src);
        end
        if (cnt_q == 3'd3) begin
          st_d  = MIX_FILT;
          cnt_d = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      MIX_FILT: begin
        filt_d = sat_f;
        dacc_d = dacc_q + (smv_q[4] ? dext(lp_q) : '0)
                        + (smv_q[5] ? dext(bp_q) : '0)
                        + (smv_q[6] ? dext(hp_q) : '0);
        st_d   = MIX_MUL;
        cnt_d  = 3'd0;
      end
      MIX_MUL: begin
        if (vmul[cnt_q]) prod_d = prod_q + (pext(dacc_q) <<< cnt_q);
        if (cnt_q == 3'd7) st_d = MIX_OUT;
        else cnt_d = cnt_q + 3'd1;
      end
      MIX_OUT: begin
        out_d = sat_o;
        vld_d = 1'b1;
        st_d  = MIX_IDLE;
      end
      default: ;
    endcase

    // A tick always restarts capture; any sample in flight is discarded.
    if (clkEn) begin
      src_d[0] = iV1;
      src_d[1] = iV2;
      src_d[2] = iV3;
      src_d[3] = iExt;
      lp_d     = iLP;
      bp_d     = iBP;
      hp_d     = iHP;
      sfen_d   = fen_q;
      smv_d    = mv_q;
      facc_d   = '0;
      dacc_d   = '0;
      prod_d   = '0;
      filt_d   = filt_q;
      out_d    = out_q;
      vld_d    = 1'b0;
      st_d     = MIX_VOICE;
      cnt_d    = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fen_q  <= '0;
      mv_q   <= '0;
      for (int i = 0; i < 4; i++) src_q[i] <= '0;
      lp_q   <= '0;
      bp_q   <= '0;
      hp_q   <= '0;
      sfen_q <= '0;
      smv_q  <= '0;
      st_q   <= MIX_IDLE;
      cnt_q  <= '0;
      facc_q <= '0;
      dacc_q <= '0;
      prod_q <= '0;
      filt_q <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      fen_q  <= fen_d;
      mv_q   <= mv_d;
      src_q  <= src_d;
      lp_q   <= lp_d;
      bp_q   <= bp_d;
      hp_q   <= hp_d;
      sfen_q <= sfen_d;
      smv_q  <= smv_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      facc_q <= facc_d;
      dacc_q <= dacc_d;
      prod_q <= prod_d;
      filt_q <= filt_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
    end
  end

  assign oFiltIn = filt_q;
  assign oOut    = out_q;
  assign oValid  = vld_q;

endmodule

// File: tb/tb_sid_mixer.sv
// Scoreboard bench for sid_mixer: stimulus pushes model results, a negedge
// monitor pops them whenever oValid is seen.
module tb_sid_mixer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clkEn = 1'b0;
  logic signed [15:0] iV1 = '0, iV2 = '0, iV3 = '0, iExt = '0;
  logic signed [15:0] iLP = '0, iBP = '0, iHP = '0;
  logic WR = 1'b0;
  logic [4:0] ADDR = '0;
  logic [7:0] DATA = '0;
  logic signed [15:0] oFiltIn, oOut;
  logic oValid;

  sid_mixer #(.W(16)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn),
    .iV1(iV1), .iV2(iV2), .iV3(iV3), .iExt(iExt),
    .iLP(iLP), .iBP(iBP), .iHP(iHP),
    .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .oFiltIn(oFiltIn), .oOut(oOut), .oValid(oValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int out;
    int filt;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] fen_m = '0;
  logic [7:0] mv_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference: sum routed sources, then multiply by vol*17 (= {vol,vol}) and divide by 256.
  function automatic exp_t model(input int cyc_exp);
    exp_t   r;
    longint facc = 0;
    longint dacc = 0;
    longint p;
    int     s[4];
    s[0] = int'(iV1); s[1] = int'(iV2); s[2] = int'(iV3); s[3] = int'(iExt);
    for (int i = 0; i < 4; i++) begin
      if (fen_m[i]) facc += s[i];
      else if (!(i == 2 && mv_m[7])) dacc += s[i];
    end
    if (mv_m[4]) dacc += int'(iLP);
    if (mv_m[5]) dacc += int'(iBP);
    if (mv_m[6]) dacc += int'(iHP);
    p = dacc * longint'(int'(mv_m[3:0]) * 17);
    r.out  = sat16(p >>> 8);
    r.filt = sat16(facc);
    r.cyc  = cyc_exp;
    return r;
  endfunction

  always @(negedge clk) begin
    if (oValid) begin
      if (q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("oOut", longint'(oOut), longint'(e.out));
        chk("oFiltIn", longint'(oFiltIn), longint'(e.filt));
        chk("valid_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    WR = 1'b1; ADDR = a; DATA = d;
    @(posedge clk); #1;
    WR = 1'b0;
    if (a == 5'h17) fen_m = d[3:0];
    if (a == 5'h18) mv_m = d;
  endtask

  function automatic logic signed [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'sh8000;
      1: return 16'sh7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic scramble();
    iV1 = rnd16(); iV2 = rnd16(); iV3 = rnd16(); iExt = rnd16();
    iLP = rnd16(); iBP = rnd16(); iHP = rnd16();
  endtask

  task automatic set_src(input int v1, input int v2, input int v3, input int ext,
                         input int lp, input int bp, input int hp);
    iV1 = 16'(v1); iV2 = 16'(v2); iV3 = 16'(v3); iExt = 16'(ext);
    iLP = 16'(lp); iBP = 16'(bp); iHP = 16'(hp);
  endtask

  // Pulses clkEn; inputs are scrambled right after capture to prove snapshotting.
  task automatic fire(input bit expect_it);
    @(posedge clk); #1;
    clkEn = 1'b1;
    @(posedge clk); #1;
    clkEn = 1'b0;
    if (expect_it) q.push_back(model(cyc + 14));
    scramble();
  endtask

  initial begin
    idle(3);
    @(negedge clk);
    chk("reset_oOut", longint'(oOut), 0);
    chk("reset_oFiltIn", longint'(oFiltIn), 0);
    chk("reset_oValid", longint'(oValid), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    set_src(1000, 1000, 1000, 1000, 0, 0, 0);
    fire(1); idle(15);

    wr(5'h18, 8'h0F); wr(5'h17, 8'h00);
    set_src(1000, 1000, 1000, 0, 0, 0, 0);
    fire(1); idle(15);

    wr(5'h17, 8'h03); wr(5'h18, 8'h1F);
    set_src(20000, 20000, 100, 0, -4000, 0, 0);
    fire(1); idle(15);

    wr(5'h17, 8'h00); wr(5'h18, 8'h8F);
    set_src(0, 0, 5000, 0, 0, 0, 0);
    fire(1); idle(15);
    wr(5'h17, 8'h04);
    set_src(0, 0, 5000, 0, 0, 0, 0);
    fire(1); idle(15);

    wr(5'h17, 8'h00); wr(5'h18, 8'h7F);
    set_src(-32768, -32768, -32768, -32768, -32768, -32768, -32768);
    fire(1); idle(15);

    wr(5'h17, 8'h0F); wr(5'h18, 8'h0F);
    set_src(32767, 32767, 32767, 32767, 0, 0, 0);
    fire(1); idle(15);

    for (int n = 0; n < 30; n++) begin
      wr(5'h17, 8'($urandom)); wr(5'h18, 8'($urandom));
      scramble();
      fire(1);
      idle(2);
      wr(($urandom_range(0, 1) == 0) ? 5'h17 : 5'h18, 8'($urandom));
      wr(5'h03, 8'($urandom));
      idle($urandom_range(10, 20));
    end

    wr(5'h17, 8'h00); wr(5'h18, 8'h0F);
    set_src(1200, -300, 700, 50, 0, 0, 0);
    fire(0);
    idle(4);
    set_src(-2500, 900, 10, 4000, 0, 0, 0);
    fire(1); idle(20);

    set_src(3000, 3000, 3000, 3000, 0, 0, 0);
    fire(0);
    idle(7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fen_m = '0;
    mv_m = '0;
    chk("post_rst_oOut", longint'(oOut), 0);
    chk("post_rst_oFiltIn", longint'(oFiltIn), 0);
    chk("post_rst_oValid", longint'(oValid), 0);
    idle(20);

    set_src(1000, 1000, 1000, 0, 0, 0, 0);
    fire(1); idle(15);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", longint'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
